// File: rtl/fetch_pc_pkg.sv
// rtl/fetch_pc_pkg.sv - shared CPU constants: next-PC opcodes and reset vector
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Branch offset is in words: sign-extend and scale to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_npc.sv
// rtl/fetch_pc_npc.sv - combinational next-PC target; FETCH_PC_ALIGN_CHECK_EN adds jr alignment
module npc
  import fetch_pc_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_npc_op,
  input  logic        i_br_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  input  logic [31:0] i_jr_target,
`ifdef FETCH_PC_ALIGN_CHECK_EN
  output logic        o_jr_misalign,
`endif
  output logic [31:0] o_target,
  output logic        o_redirect
);

  logic [31:0] w_pc4;

  assign w_pc4 = i_pc + 32'd4;

  always_comb begin
    o_target   = w_pc4;
    o_redirect = 1'b0;
`ifdef FETCH_PC_ALIGN_CHECK_EN
    o_jr_misalign = 1'b0;
`endif
    case (npc_op_e'(i_npc_op))
      NPC_SEQ: o_target = w_pc4;
      NPC_BR: begin
        if (i_br_taken) begin
          o_target   = w_pc4 + br_offset(i_imm16);
          o_redirect = 1'b1;
        end
      end
      NPC_J: begin
        o_target   = {w_pc4[31:28], i_instr_index, 2'b00};
        o_redirect = 1'b1;
      end
      NPC_JR: begin
`ifdef FETCH_PC_ALIGN_CHECK_EN
        o_target      = {i_jr_target[31:2], 2'b00};
        o_jr_misalign = |i_jr_target[1:0];
`else
        o_target      = i_jr_target;
`endif
        o_redirect = 1'b1;
      end
      default: o_target = w_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - fetch PC register with stall-buffered redirect; FETCH_PC_ALIGN_CHECK_EN enables jr alignment flag
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       npc_op,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus8,
  output logic             redirect_pending,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [31:0]      r_pc;
  logic [31:0]      r_pend_tgt;
  logic             r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_target;
  logic             w_redirect;

`ifdef FETCH_PC_ALIGN_CHECK_EN
  logic w_jr_misalign;
  logic r_misalign;
`endif

  npc u_npc (
    .i_pc          (r_pc),
    .i_npc_op      (npc_op),
    .i_br_taken    (br_taken),
    .i_imm16       (imm16),
    .i_instr_index (instr_index),
    .i_jr_target   (jr_target),
`ifdef FETCH_PC_ALIGN_CHECK_EN
    .o_jr_misalign (w_jr_misalign),
`endif
    .o_target      (w_target),
    .o_redirect    (w_redirect)
  );

  // A redirect seen while stalled is held and takes priority at release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_tgt <= 32'd0;
      r_cnt      <= '0;
    end else if (stall) begin
      if (w_redirect) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= w_target;
      end
    end else begin
      r_pc   <= r_pend ? r_pend_tgt : w_target;
      r_pend <= 1'b0;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

`ifdef FETCH_PC_ALIGN_CHECK_EN
  // The jr is accepted when pended (stalled) or loaded (not masked by a pending one).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (w_jr_misalign && (stall || !r_pend)) begin
      r_misalign <= 1'b1;
    end
  end
  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  assign pc               = r_pc;
  assign pc_plus8         = r_pc + 32'd8;
  assign redirect_pending = r_pend;
  assign fetch_cnt        = r_cnt;

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard bench for fetch_pc; honours FETCH_PC_ALIGN_CHECK_EN
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] instr_index = 26'h0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        redirect_pending;
  logic        misalign;
  logic [31:0] fetch_cnt;

  fetch_pc dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .npc_op           (npc_op),
    .br_taken         (br_taken),
    .imm16            (imm16),
    .instr_index      (instr_index),
    .jr_target        (jr_target),
    .pc               (pc),
    .pc_plus8         (pc_plus8),
    .redirect_pending (redirect_pending),
    .misalign         (misalign),
    .fetch_cnt        (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  op;
    logic        br;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] pc;
    logic        pend;
    logic        adv;
  } step_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 0;

  function automatic step_t mk(logic s, logic [1:0] op, logic br, logic [15:0] imm,
                               logic [25:0] idx, logic [31:0] jr, logic [31:0] epc,
                               logic pend, logic adv);
    step_t r;
    r.stall = s; r.op = op; r.br = br; r.imm = imm; r.idx = idx; r.jr = jr;
    r.pc = epc; r.pend = pend; r.adv = adv;
    return r;
  endfunction

  task automatic apply(input string name, input step_t s);
    stall = s.stall; npc_op = s.op; br_taken = s.br; imm16 = s.imm;
    instr_index = s.idx; jr_target = s.jr;
    if (s.adv) exp_cnt = exp_cnt + 1;
    sb.push_back('{name, s.pc, exp_cnt, s.pend});
  endtask

  task automatic pulse_reset_midcycle(input string name);
    #2 reset = 1'b1;
    exp_cnt = 0;
    #1;
    n_checks++;
    if (pc !== 32'h3000 || fetch_cnt !== 32'd0 || redirect_pending !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: pc=%h cnt=%0d pend=%b mis=%b, expected pc=00003000 cnt=0 pend=0 mis=0",
               name, pc, fetch_cnt, redirect_pending, misalign);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    step_t t[$];
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (pc !== 32'h3000 || fetch_cnt !== 32'd0 || redirect_pending !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: pc=%h cnt=%0d pend=%b mis=%b, expected pc=00003000 cnt=0 pend=0 mis=0",
               pc, fetch_cnt, redirect_pending, misalign);
    end
    @(negedge clk) reset = 1'b0;
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 0, 1));
    foreach (t[i]) begin
      apply("reset_seq", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
      end
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    t.push_back(mk(0, 2'b00, 0, 16'h0,    26'h0, 32'h0, 32'h3010, 0, 1));
    t.push_back(mk(0, 2'b01, 1, 16'hFFFE, 26'h0, 32'h0, 32'h300C, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0,    26'h0, 32'h0, 32'h3010, 0, 1));
    t.push_back(mk(0, 2'b01, 0, 16'hFFFE, 26'h0, 32'h0, 32'h3014, 0, 1));
    foreach (t[i]) begin
      apply("branch", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
      end
    end
  endtask

  task automatic test_jump();
    pulse_reset_midcycle("jump_reset");
    n_checks++;
    if (pc_plus8 !== 32'h3008) begin
      n_fail++;
      $display("FAIL jump_pc_plus8: got %h, expected 00003008", pc_plus8);
    end
    apply("jump", mk(0, 2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 0, 1));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
      n_fail++;
      $display("FAIL %s: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
               e.name, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
    end
  endtask

  task automatic test_stall_redirect();
    step_t t[$];
    t.push_back(mk(1, 2'b11, 0, 16'h0, 26'h0, 32'h3100, 32'h3040, 1, 0));
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0,    32'h3100, 0, 1));
    t.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 32'h0,    32'h3100, 0, 0));
    t.push_back(mk(1, 2'b01, 0, 16'h8, 26'h0, 32'h0,    32'h3100, 0, 0));
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0,    32'h3104, 0, 1));
    foreach (t[i]) begin
      apply("stall_redirect", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
      end
    end
  endtask

  task automatic test_pending_overwrite();
    step_t t[$];
    t.push_back(mk(1, 2'b11, 0, 16'h0,    26'h0, 32'h3100, 32'h3104, 1, 0));
    t.push_back(mk(1, 2'b11, 0, 16'h0,    26'h0, 32'h3200, 32'h3104, 1, 0));
    t.push_back(mk(1, 2'b00, 0, 16'h0,    26'h0, 32'h0,    32'h3104, 1, 0));
    t.push_back(mk(0, 2'b11, 0, 16'h0,    26'h0, 32'h5000, 32'h3200, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0,    26'h0, 32'h0,    32'h3204, 0, 1));
    t.push_back(mk(1, 2'b01, 1, 16'h0004, 26'h0, 32'h0,    32'h3204, 1, 0));
    t.push_back(mk(0, 2'b00, 0, 16'h0,    26'h0, 32'h0,    32'h3218, 0, 1));
    foreach (t[i]) begin
      apply("pend_overwrite", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t t[$];
    t.push_back(mk(1, 2'b11, 0, 16'h0, 26'h0, 32'h3300, 32'h3218, 1, 0));
    foreach (t[i]) begin
      apply("mid_stall", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
      end
    end
    pulse_reset_midcycle("mid_stall_reset");
    apply("post_reset", mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 1));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
      n_fail++;
      $display("FAIL %s: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
               e.name, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
    end
  endtask

  task automatic test_wrap();
    step_t t[$];
    t.push_back(mk(0, 2'b11, 0, 16'h0,    26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0,    26'h0, 32'h0,         32'h0000_0000, 0, 1));
    t.push_back(mk(0, 2'b01, 1, 16'h8000, 26'h0, 32'h0,         32'hFFFE_0004, 0, 1));
    foreach (t[i]) begin
      apply("wrap", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b, expected pc=%h cnt=%0d pend=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, e.pc, e.cnt, e.pend);
      end
      if (i == 0) begin
        n_checks++;
        if (pc_plus8 !== 32'h0000_0004) begin
          n_fail++;
          $display("FAIL wrap_pc_plus8: got %h, expected 00000004", pc_plus8);
        end
      end
    end
  endtask

  task automatic test_align();
    step_t t[$];
    logic exp_mis;
`ifdef FETCH_PC_ALIGN_CHECK_EN
    exp_mis = 1'b1;
    t.push_back(mk(0, 2'b11, 0, 16'h0, 26'h0, 32'h3106, 32'h3104, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0,    32'h3108, 0, 1));
`else
    exp_mis = 1'b0;
    t.push_back(mk(0, 2'b11, 0, 16'h0, 26'h0, 32'h3106, 32'h3106, 0, 1));
    t.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 32'h0,    32'h310A, 0, 1));
`endif
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL align_pre: misalign=%b, expected 0", misalign);
    end
    foreach (t[i]) begin
      apply("align", t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_cnt !== e.cnt || redirect_pending !== e.pend || misalign !== exp_mis) begin
        n_fail++;
        $display("FAIL %s[%0d]: pc=%h cnt=%0d pend=%b mis=%b, expected pc=%h cnt=%0d pend=%b mis=%b",
                 e.name, i, pc, fetch_cnt, redirect_pending, misalign, e.pc, e.cnt, e.pend, exp_mis);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_stall_redirect();
    test_pending_overwrite();
    test_reset_mid_stall();
    test_wrap();
    test_align();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000: PC value loaded by reset.
REQ-002 SHALL have parameter CNT_W, default 32: width of the fetch counter.
REQ-003 SHALL have port clk  in  1: single clock, rising-edge active.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port stall  in  1: 1 = hold PC this cycle.
REQ-006 SHALL have port npc_op  in  2: 00 sequential, 01 branch, 10 j/jal, 11 jr.
REQ-007 SHALL have port br_taken  in  1: branch condition; used only when npc_op=01.
REQ-008 SHALL have port imm16  in  16: branch offset, in words.
REQ-009 SHALL have port instr_index  in  26: j/jal target field.
REQ-010 SHALL have port jr_target  in  32: register target for jr.
REQ-011 SHALL have port pc  out  32: current fetch address, driven to the instruction memory Addr input.
REQ-012 SHALL have port pc_plus8  out  32: pc+8, the jal link value.
REQ-013 SHALL have port redirect_pending  out  1: a buffered redirect is waiting.
REQ-014 SHALL have port misalign  out  1: sticky misaligned-jr flag.
REQ-015 SHALL have port fetch_cnt  out  CNT_W: count of PC advances since reset.

Function
REQ-016 SHALL compute pc4 = pc+4, wrapping modulo 2^32.
REQ-017 SHALL define the target: seq -> pc4; branch taken -> pc4 + (sign-extended imm16 << 2); branch not taken -> pc4; j -> {pc4[31:28], instr_index, 2'b00}; jr -> jr_target.
REQ-018 SHALL define a redirect as npc_op=10, npc_op=11, or npc_op=01 with br_taken=1.
REQ-019 SHALL, at a rising edge with stall=0 and redirect_pending=0, load pc <= target; latency from inputs to pc is one edge.
REQ-020 SHALL, at a rising edge with stall=1, hold pc and fetch_cnt unchanged.
REQ-021 SHALL, at a stalled edge where a redirect is presented, latch its target into a pending register and set redirect_pending=1.
REQ-022 SHALL, if a redirect arrives while already pending and still stalled, overwrite the pending target with the newest one.
REQ-023 SHALL, at the first edge with stall=0 and redirect_pending=1, load pc <= pending target and clear redirect_pending; current npc_op is ignored on that edge.
REQ-024 SHALL increment fetch_cnt by 1 on every edge where pc loads, wrapping at 2^CNT_W.
REQ-025 SHALL drive pc_plus8 combinationally as pc+8, wrapping modulo 2^32.
REQ-026 SHALL NOT range-check pc; the consumer indexes memory by its low address bits.

Reset
REQ-027 SHALL, on reset assertion, immediately set pc=RESET_PC, redirect_pending=0, pending target=0, misalign=0 and fetch_cnt=0, regardless of clk.
REQ-028 SHALL discard any pending redirect when reset asserts mid-stall.
REQ-029 SHALL perform its first advance at the first rising edge after reset deasserts, with stall=0.

Configuration
REQ-030 SHALL, when macro FETCH_PC_ALIGN_CHECK_EN is defined, force bits [1:0] of a jr target to 0 before it is loaded or pended, and set misalign=1 (sticky until reset) if jr_target[1:0]!=0 at the accepting edge.
REQ-031 SHALL, when FETCH_PC_ALIGN_CHECK_EN is undefined, load jr_target unmodified and tie misalign to 0.

Structure
REQ-032 SHALL place the npc_op encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR) and the default RESET_PC constant in the shared CPU package.
REQ-033 SHALL implement target calculation as a combinational sub-module npc; fetch_pc holds all state (pc, pending register, counter, flag).

Verification
REQ-034 SHALL test reset: reset=1 mid-cycle -> pc=0x00003000 and fetch_cnt=0 without waiting for a clock edge; 3 sequential edges -> pc=0x0000300C and fetch_cnt=3.
REQ-035 SHALL test branches: pc=0x3010, npc_op=01, br_taken=1, imm16=0xFFFE -> pc=0x300C; same inputs with br_taken=0 -> pc=0x3014.
REQ-036 SHALL test jump: pc=0x3000, npc_op=10, instr_index=0x0000C10 -> pc=0x00003040; pc_plus8=0x3008 before that edge.
REQ-037 SHALL test a stalled redirect: stall=1 with jr_target=0x3100, then npc_op=00 and stall=0 -> pc holds at the stalled edge, redirect_pending=1, next edge pc=0x3100 and redirect_pending=0.
REQ-038 SHALL test pending overwrite: two redirects to 0x3100 then 0x3200 during one stall -> pc=0x3200 after release; fetch_cnt advances by exactly 1.
REQ-039 SHALL test alignment: with FETCH_PC_ALIGN_CHECK_EN, jr_target=0x3106 -> pc=0x3104 and misalign=1; without the macro -> pc=0x3106 and misalign=0.
